// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: captures rising edges on N_CH level inputs, holds per-channel pending
// flags and serves them round-robin over valid/ready. Optional macro: EDGE_ARB_SYNC_EN.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   signal,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [N_CH-1:0]   evt_pending,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_drop,
  output logic              state_dbg
);

  // Handshake: an event transfers on a rising clk edge where evt_valid and evt_ready are both 1;
  // while evt_valid is 1 and evt_ready is 0, evt_valid and evt_ch hold stable.

  localparam int PW = $clog2(N_CH + 1);
  localparam int SW = CNT_W + PW;

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [N_CH-1:0]   sig_s, prev, edge_det, pending, pending_nxt;
  logic [N_CH-1:0]   clr_mask, drop_vec;
  logic [CH_W-1:0]   last, winner;
  logic              any_pend, hs;
  logic [PW-1:0]     drop_num;
  logic [SW-1:0]     drop_sum;
  logic [CNT_W-1:0]  drop_nxt;

`ifdef EDGE_ARB_SYNC_EN
  logic [N_CH-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= signal;
      sync_q2 <= sync_q1;
    end
  end

  assign sig_s = sync_q2;
`else
  assign sig_s = signal;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= sig_s;
  end

  assign edge_det    = sig_s & ~prev;
  assign hs          = evt_valid & evt_ready;
  assign evt_pending = pending;

  // Round-robin: smallest circular distance from last+1 among set flags wins.
  always_comb begin
    int best_d;
    int d;
    best_d   = N_CH;
    d        = 0;
    winner   = '0;
    any_pend = |pending;
    for (int i = 0; i < N_CH; i++) begin
      d = i - int'(last) - 1;
      if (d < 0) d = d + N_CH;
      if (pending[i] && (d < best_d)) begin
        best_d = d;
        winner = CH_W'(i);
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr_mask[i] = hs && (evt_ch == CH_W'(i));
    end
  end

  // A clear colliding with a new edge leaves the flag set and is not a drop.
  assign drop_vec    = edge_det & pending & ~clr_mask;
  assign pending_nxt = (pending & ~clr_mask) | edge_det;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_num = drop_num + PW'(drop_vec[i]);
    end
    drop_sum = SW'(drop_cnt) + SW'(drop_num);
    if (clr_drop)                  drop_nxt = '0;
    else if (|drop_sum[SW-1:CNT_W]) drop_nxt = '1;
    else                           drop_nxt = drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_ch <= '0;
      last   <= CH_W'(N_CH - 1);
    end else begin
      if ((state == IDLE) && any_pend) evt_ch <= winner;
      if (hs)                          last   <= evt_ch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend)  state_nxt = OFFER;
      OFFER:   if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
    state_dbg = (state == OFFER);
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: two DUTs (CNT_W 8 and 2) share stimulus; a spec-level model
// predicts grants into exp_q and per-cycle flags/counters, checked by a negedge monitor.
module tb_edge_event_arbiter;
  localparam int N_CH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] signal = 4'h0;
  logic       evt_ready = 1'b0;
  logic       clr_drop = 1'b0;

  logic       evt_valid, evt_valid_b, state_dbg, state_dbg_b;
  logic [1:0] evt_ch, evt_ch_b;
  logic [3:0] evt_pending, evt_pending_b;
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  edge_event_arbiter #(.N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .signal(signal), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_pending(evt_pending), .drop_cnt(drop_cnt), .clr_drop(clr_drop),
    .state_dbg(state_dbg)
  );

  edge_event_arbiter #(.N_CH(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .signal(signal), .evt_valid(evt_valid_b), .evt_ready(evt_ready),
    .evt_ch(evt_ch_b), .evt_pending(evt_pending_b), .drop_cnt(drop_cnt_b), .clr_drop(clr_drop),
    .state_dbg(state_dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [3:0] m_pend, m_prev, m_s1, m_s2, m_sig, m_edge;
  int         m_last, m_ch, m_drops, m_win, m_ndrop;
  bit         m_offer, m_hs, m_cleared;
  logic [1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_last = N_CH - 1; m_ch = 0; m_drops = 0; m_offer = 0;
      exp_q.delete();
    end else begin
`ifdef EDGE_ARB_SYNC_EN
      m_sig = m_s2; m_s2 = m_s1; m_s1 = signal;
`else
      m_sig = signal;
`endif
      m_edge = m_sig & ~m_prev;
      m_prev = m_sig;
      m_hs   = m_offer && evt_ready;
      if (!m_offer) begin
        m_win = -1;
        for (int k = 1; k <= N_CH; k++)
          if (m_win < 0 && m_pend[(m_last + k) % N_CH]) m_win = (m_last + k) % N_CH;
        if (m_win >= 0) begin
          m_offer = 1; m_ch = m_win;
          exp_q.push_back(2'(m_win));
        end
      end
      m_ndrop = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_cleared = m_hs && (m_ch == i);
        if (m_edge[i] && m_pend[i] && !m_cleared) m_ndrop++;
        if (m_edge[i]) m_pend[i] = 1'b1;
        else if (m_cleared) m_pend[i] = 1'b0;
      end
      if (clr_drop) m_drops = 0;
      else m_drops = m_drops + m_ndrop;
      if (m_hs) begin
        m_offer = 0; m_last = m_ch;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_ch", int'(evt_ch), 0);
      chk("rst_pending", int'(evt_pending), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      chk("rst_valid_b", int'(evt_valid_b), 0);
    end else begin
      chk("valid", int'(evt_valid), int'(m_offer));
      chk("state_dbg", int'(state_dbg), int'(m_offer));
      chk("pending", int'(evt_pending), int'(m_pend));
      chk("drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
      chk("valid_b", int'(evt_valid_b), int'(m_offer));
      chk("pending_b", int'(evt_pending_b), int'(m_pend));
      chk("drop_cnt_b", int'(drop_cnt_b), (m_drops > 3) ? 3 : m_drops);
      if (m_offer) begin
        chk("evt_ch", int'(evt_ch), m_ch);
        chk("evt_ch_b", int'(evt_ch_b), m_ch);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) chk("grant_unexpected", 1, 0);
        else chk("grant_ch", int'(evt_ch), int'(exp_q.pop_front()));
      end
    end
  end

  // driver
  task automatic drive(input logic [3:0] s, input logic r, input logic c, input int n);
    repeat (n) begin
      @(posedge clk); #3;
      signal = s; evt_ready = r; clr_drop = c;
    end
  endtask

  initial begin
    // reset held with all inputs high, then edges on all four channels
    drive(4'hF, 1'b0, 1'b0, 3);
    @(posedge clk); #3; reset = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 10);
    drive(4'h0, 1'b1, 1'b0, 3);
    // single edge, consumer always ready
    drive(4'b0100, 1'b1, 1'b0, 4);
    drive(4'h0, 1'b1, 1'b0, 2);
    // round-robin order
    drive(4'b1011, 1'b1, 1'b0, 8);
    drive(4'h0, 1'b1, 1'b0, 2);
    drive(4'b1001, 1'b1, 1'b0, 6);
    drive(4'h0, 1'b1, 1'b0, 2);
    // back-pressure with two drops on channel 1, then clear
    drive(4'b0010, 1'b0, 1'b0, 3);
    drive(4'b0000, 1'b0, 1'b0, 1);
    drive(4'b0010, 1'b0, 1'b0, 1);
    drive(4'b0000, 1'b0, 1'b0, 1);
    drive(4'b0010, 1'b0, 1'b0, 1);
    drive(4'b0010, 1'b0, 1'b1, 1);
    drive(4'b0010, 1'b0, 1'b0, 2);
    // handshake colliding with a new edge on the offered channel
    drive(4'b0000, 1'b0, 1'b0, 1);
    drive(4'b0010, 1'b1, 1'b0, 1);
    drive(4'b0010, 1'b1, 1'b0, 4);
    drive(4'h0, 1'b1, 1'b0, 2);
    // saturation: many drops while stalled
    drive(4'b0001, 1'b0, 1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      drive(4'h0, 1'b0, 1'b0, 1);
      drive(4'hF, 1'b0, 1'b0, 1);
    end
    drive(4'hF, 1'b0, 1'b0, 2);
    // asynchronous reset while an event is offered
    @(posedge clk); #3; reset = 1'b1;
    #1;
    chk("async_valid", int'(evt_valid), 0);
    chk("async_pending", int'(evt_pending), 0);
    chk("async_drop", int'(drop_cnt), 0);
    drive(4'h0, 1'b0, 1'b0, 2);
    @(posedge clk); #3; reset = 1'b0;
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 24) == 0), 1);
    end
    drive(4'h0, 1'b1, 1'b0, 12);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Captures rising edges on `N_CH` level inputs, holds one pending flag per channel, and serves the pending events one at a time to a single consumer over a valid/ready handshake. Channels are served round-robin. Edges lost because a channel was already pending are counted. The block sits between the edge-detection layer and any shared event handler, such as an interrupt, counter or command unit, that can process only one event at a time.

## Interface
- `N_CH`, default 4: number of input channels, range 2..16.
- `CNT_W`, default 8: width of the saturating drop counter.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `signal` input, `N_CH` bits: raw level inputs, one per channel.
- `evt_valid` output, 1 bit: an event is offered on `evt_ch`.
- `evt_ready` input, 1 bit: the consumer accepts the offered event.
- `evt_ch` output, `$clog2(N_CH)` bits: channel index of the offered event.
- `evt_pending` output, `N_CH` bits: current per-channel pending flags.
- `drop_cnt` output, `CNT_W` bits: number of edges lost; saturates at all-ones.
- `clr_drop` input, 1 bit: synchronous clear of `drop_cnt`.

## Operation
- **Edge detection.** `prev[i]` registers `signal[i]` every clock and resets to 0. `edge[i] = signal[i] & ~prev[i]`. A channel that is high when reset is released therefore produces one edge on the first clock.
- **Pending flags.**
  - An edge sets `pending[i]`.
  - A completed handshake (`evt_valid & evt_ready`) on channel `evt_ch` clears that channel's flag.
  - If the clear and a new edge on the same channel occur in the same cycle, the flag stays 1 and no drop is counted.
- **Drops.**
  - A drop occurs when `edge[i]` arrives while `pending[i]` is 1 and that flag is not being cleared this cycle.
  - `drop_cnt` increases by the number of channels dropping in that cycle (popcount) and saturates at 2^CNT_W-1.
  - `clr_drop` has priority: the counter becomes 0 and drops in the same cycle are discarded.
- **State machine.** Two states, IDLE and OFFER.
  - IDLE: `evt_valid` is 0. If any pending flag is set, select the winner by round-robin, load `evt_ch`, set `evt_valid`=1 and move to OFFER.
  - OFFER: `evt_valid` is 1 and `evt_ch` is held stable. When `evt_ready` is 1, clear `pending[evt_ch]`, set `last` to `evt_ch` and return to IDLE.
  - `evt_ready` has no effect in IDLE.
- **Round-robin selection.** Search starts at `last+1` (mod `N_CH`) and takes the first set pending flag. `last` resets to `N_CH-1`, so channel 0 has priority first after reset.
- **Reset values.**
  - Outputs: `evt_valid`=0, `evt_ch`=0, `evt_pending`=0, `drop_cnt`=0.
  - Internal: state IDLE, `prev`=0, `last`=`N_CH-1`.
- **Reset mid-operation.** Asserting reset drops `evt_valid` immediately (asynchronously). Pending events are discarded and no handshake is reported.

## Timing
- **Latency without sync.** Let `signal[i]` first be sampled high at clock edge E:
  - `evt_pending[i]` is 1 after edge E.
  - `evt_valid` is 1 with `evt_ch=i` after edge E+1, if the state machine is in IDLE and channel i wins arbitration.
- **Handshake.** The handshake completes on the clock edge where `evt_valid & evt_ready` are both 1. `evt_valid` is 0 for at least one cycle after every handshake.
- **Throughput.** At most one event every 2 cycles.
- **Stability.** While `evt_valid` is 1 without `evt_ready`, `evt_ch` and `evt_valid` do not change.
- **Drop counter timing.** `drop_cnt` updates on the same edge that detects the drop.

## Configuration
- Macro: `EDGE_ARB_SYNC_EN`.
- Defined: each `signal[i]` passes through a 2-flop synchronizer, reset to 0, before edge detection. Edge-to-`evt_valid` latency becomes 4 clocks, and the inputs may be asynchronous to `clk`.
- Undefined: `signal` is used directly. The inputs must be synchronous to `clk`, and latency is 2 clocks.

## Test plan
All scenarios use `N_CH`=4 and `CNT_W`=8 unless stated otherwise.
1. **Reset.** Hold reset with `signal`=4'b1111. Required: all outputs 0 and `evt_valid` never rises during reset. After release, edges are detected on all 4 channels.
2. **Single edge with the consumer always ready.** Raise `signal`=4'b0100 at edge E with `evt_ready`=1. Required: `evt_pending`=4'b0100 after E; `evt_valid`=1 and `evt_ch`=2 after E+1; `evt_pending`=0 and `evt_valid`=0 after E+2.
3. **Round-robin order.** Apply simultaneous edges on channels 0, 1 and 3 with `evt_ready`=1. Required: grant order 0, 1, 3. Then apply simultaneous edges on channels 0 and 3. Required: order 0, 3, because `last` is 3.
4. **Back-pressure and drops.** Hold `evt_ready`=0 while channel 1 is offered, and pulse `signal[1]` low then high twice. Required: `drop_cnt`=2, with `evt_ch`=1 and `evt_valid`=1 held throughout. Then assert `clr_drop`. Required: `drop_cnt`=0.
5. **Clear-and-edge collision and saturation.**
   - Apply a new edge on `evt_ch` in the same cycle as the handshake. Required: pending stays 1 and `drop_cnt` is unchanged.
   - With `CNT_W`=2, cause 5 drops. Required: `drop_cnt`=3.
6. **Async reset and the sync option.**
   - Assert reset mid-cycle while `evt_valid`=1. Required: `evt_valid` and `evt_pending` go to 0 before the next clock edge.
   - Rerun scenario 2 with `EDGE_ARB_SYNC_EN` defined. Required: `evt_valid` rises after E+3.
